// File: rtl/q16_16_divider.sv
// rtl/q16_16_divider.sv - iterative signed Q16.16 divider with saturation and divide-by-zero flag
module q16_16_divider #(
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_q,
    output logic        out_ovf,
    output logic        out_dbz
);

    localparam int         N_CYCLES = 48 / STEPS_PER_CYCLE;
    localparam logic [5:0] N_LOAD   = 6'(N_CYCLES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [47:0] dvd;
    logic [31:0] bmag;
    logic [31:0] rem;
    logic [47:0] quo;
    logic        q_neg;
    logic        a_neg;
    logic        b_zero;

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] rem_nxt;
    logic [47:0] dvd_nxt;
    logic [47:0] quo_nxt;
    logic [32:0] trial;
    logic [31:0] fix_q;
    logic        fix_ovf;
    logic        mag_hi;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    // Two's complement magnitude; 0x8000_0000 maps to 2^31 which still fits unsigned.
    assign a_mag = in_a[31] ? (~in_a + 32'd1) : in_a;
    assign b_mag = in_b[31] ? (~in_b + 32'd1) : in_b;

    // Unrolled restoring-division steps performed in one DIV cycle.
    always_comb begin
        rem_nxt = rem;
        dvd_nxt = dvd;
        quo_nxt = quo;
        trial   = '0;
        for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
            trial   = {rem_nxt, dvd_nxt[47]};
            dvd_nxt = {dvd_nxt[46:0], 1'b0};
            if (trial >= {1'b0, bmag}) begin
                trial   = trial - {1'b0, bmag};
                quo_nxt = {quo_nxt[46:0], 1'b1};
            end else begin
                quo_nxt = {quo_nxt[46:0], 1'b0};
            end
            rem_nxt = trial[31:0];
        end
    end

    // Sign restoration and saturation of the 48-bit magnitude quotient.
    always_comb begin
        mag_hi  = |quo[47:32];
        fix_q   = quo[31:0];
        fix_ovf = 1'b0;
        if (b_zero) begin
            fix_q = a_neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (!q_neg) begin
            if (mag_hi || quo[31]) begin
                fix_q   = 32'h7FFF_FFFF;
                fix_ovf = 1'b1;
            end
        end else begin
            if (mag_hi || (quo[31] && |quo[30:0])) begin
                fix_q   = 32'h8000_0000;
                fix_ovf = 1'b1;
            end else begin
                fix_q = ~quo[31:0] + 32'd1;
            end
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_IDLE;
            cnt     <= '0;
            dvd     <= '0;
            bmag    <= '0;
            rem     <= '0;
            quo     <= '0;
            q_neg   <= 1'b0;
            a_neg   <= 1'b0;
            b_zero  <= 1'b0;
            out_q   <= '0;
            out_ovf <= 1'b0;
            out_dbz <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        dvd    <= {a_mag, 16'h0000};
                        bmag   <= b_mag;
                        rem    <= '0;
                        quo    <= '0;
                        q_neg  <= in_a[31] ^ in_b[31];
                        a_neg  <= in_a[31];
                        b_zero <= (in_b == 32'h0000_0000);
                        cnt    <= N_LOAD;
                        state  <= S_DIV;
                    end
                end
                S_DIV: begin
                    dvd <= dvd_nxt;
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt - 6'd1;
                    if (cnt == 6'd1) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    out_q   <= fix_q;
                    out_ovf <= fix_ovf;
                    out_dbz <= b_zero;
                    state   <= S_DONE;
                end
                default: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_q16_16_divider.sv
// tb/tb_q16_16_divider.sv - bench for q16_16_divider at one and eight steps per cycle
module tb_q16_16_divider;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_ready;

    logic        ir1, ov1, ovf1, dbz1;
    logic [31:0] q1;
    logic        ir8, ov8, ovf8, dbz8;
    logic [31:0] q8;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic        ovf;
        logic        dbz;
    } vec_t;

    vec_t tbl[11];

    q16_16_divider #(.STEPS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ir1),
        .in_a(in_a), .in_b(in_b), .out_valid(ov1), .out_ready(out_ready),
        .out_q(q1), .out_ovf(ovf1), .out_dbz(dbz1)
    );

    q16_16_divider #(.STEPS_PER_CYCLE(8)) dut8 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ir8),
        .in_a(in_a), .in_b(in_b), .out_valid(ov8), .out_ready(out_ready),
        .out_q(q8), .out_ovf(ovf8), .out_dbz(dbz8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: signed division of a*2^16 by b with truncation toward zero, then clamping.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic ovf, output logic dbz);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) begin
            dbz = 1'b1;
            ovf = 1'b0;
            q   = (sa < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            dbz = 1'b0;
            r   = (sa * 65536) / sb;
            if (r > 64'sd2147483647) begin
                q = 32'h7FFF_FFFF; ovf = 1'b1;
            end else if (r < -64'sd2147483648) begin
                q = 32'h8000_0000; ovf = 1'b1;
            end else begin
                q = r[31:0]; ovf = 1'b0;
            end
        end
    endfunction

    // Issue one operation to both instances, check latency and results.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] eq,
                         input logic eovf, input logic edbz, input string name);
        int lat1, lat8;
        logic [31:0] cq1, cq8;
        logic co1, cd1, co8, cd8;
        lat1 = -1; lat8 = -1;
        cq1 = 'x; cq8 = 'x; co1 = 'x; cd1 = 'x; co8 = 'x; cd8 = 'x;
        @(negedge clk);
        chk({name, " in_ready"}, {31'd0, ir1}, 32'd1);
        in_a = a; in_b = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a = $urandom; in_b = $urandom;
        for (int c = 1; c <= 120 && (lat1 < 0 || lat8 < 0); c++) begin
            @(posedge clk);
            #1;
            if (lat8 < 0 && ov8) begin
                lat8 = c; cq8 = q8; co8 = ovf8; cd8 = dbz8;
            end
            if (lat1 < 0 && ov1) begin
                lat1 = c; cq1 = q1; co1 = ovf1; cd1 = dbz1;
            end
        end
        chk({name, " lat1"}, lat1, 32'd49);
        chk({name, " lat8"}, lat8, 32'd7);
        chk({name, " q1"}, cq1, eq);
        chk({name, " ovf1"}, {31'd0, co1}, {31'd0, eovf});
        chk({name, " dbz1"}, {31'd0, cd1}, {31'd0, edbz});
        chk({name, " q8"}, cq8, eq);
        chk({name, " ovf8"}, {31'd0, co8}, {31'd0, eovf});
        chk({name, " dbz8"}, {31'd0, cd8}, {31'd0, edbz});
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] ra, rb, rq, hq;
        logic        rovf, rdbz, hovf, hdbz, bad;

        tbl[0]  = '{32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0};
        tbl[1]  = '{32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 1'b0, 1'b0};
        tbl[2]  = '{32'h0001_0000, 32'hFFFD_0000, 32'hFFFF_AAAB, 1'b0, 1'b0};
        tbl[3]  = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0};
        tbl[4]  = '{32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0, 1'b0};
        tbl[5]  = '{32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_FFFF, 1'b1, 1'b0};
        tbl[6]  = '{32'hFFFE_0000, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1};
        tbl[7]  = '{32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1};
        tbl[8]  = '{32'hFFFF_FFFF, 32'h0002_0000, 32'h0000_0000, 1'b0, 1'b0};
        tbl[9]  = '{32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0};
        tbl[10] = '{32'h000A_0000, 32'h0004_0000, 32'h0002_8000, 1'b0, 1'b0};

        rstn = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst in_ready", {31'd0, ir1}, 32'd1);
        chk("rst out_valid", {31'd0, ov1}, 32'd0);
        chk("rst out_q", q1, 32'd0);
        chk("rst ovf_dbz", {30'd0, ovf1, dbz1}, 32'd0);
        chk("rst out_valid8", {31'd0, ov8}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 11; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].ovf, tbl[i].dbz, $sformatf("vec%0d", i));
        end

        // Backpressure: result must stay frozen and new operands must be ignored.
        out_ready = 1'b0;
        do_op(32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0, "bp");
        hq = q1; hovf = ovf1; hdbz = dbz1;
        chk("bp held valid", {31'd0, ov1}, 32'd1);
        bad = 1'b0;
        in_a = 32'h0100_0000; in_b = 32'h0001_0000; in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (!ov1 || ir1 || q1 !== hq || ovf1 !== hovf || dbz1 !== hdbz) bad = 1'b1;
        end
        chk("bp stable", {31'd0, bad}, 32'd0);
        chk("bp q value", q1, 32'h0001_8000);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp in_ready after", {31'd0, ir1}, 32'd1);
        chk("bp out_valid after", {31'd0, ov1}, 32'd0);
        chk("bp in_ready8 after", {31'd0, ir8}, 32'd1);

        // Asynchronous reset in the middle of a division.
        @(negedge clk);
        in_a = 32'h0005_0000; in_b = 32'h0003_0000; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("mid in_ready busy", {31'd0, ir1}, 32'd0);
        rstn = 1'b0;
        #1;
        chk("arst out_valid", {31'd0, ov1}, 32'd0);
        chk("arst in_ready", {31'd0, ir1}, 32'd1);
        chk("arst out_q", q1, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 70; c++) begin
            @(posedge clk);
            #1;
            if (ov1 || ov8) bad = 1'b1;
        end
        chk("arst no result", {31'd0, bad}, 32'd0);
        do_op(32'h000A_0000, 32'h0004_0000, 32'h0002_8000, 1'b0, 1'b0, "post_rst");

        // Randomised operands against the reference model.
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1:       rb = $urandom & 32'h0000_00FF;
                2:       rb = $urandom & 32'h0003_FFFF;
                3:       rb = -($urandom & 32'h0003_FFFF);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = ra >>> $urandom_range(0, 24);
            model(ra, rb, rq, rovf, rdbz);
            do_op(ra, rb, rq, rovf, rdbz, $sformatf("rnd%0d a=%h b=%h", i, ra, rb));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
